// File: rtl/ar_txd_fifo.sv
// rtl/ar_txd_fifo.sv - ARINC-429-style bipolar RZ transmitter with word FIFO
module ar_txd_fifo #(
    parameter int CLK_HZ   = 50000000,
    parameter int DEPTH    = 8,
    parameter int GAP_BITS = 4,
    parameter int PAR_ODD  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               Nvel,
    input  logic                     wr_en,
    input  logic [7:0]               ADR,
    input  logic [22:0]              DAT,
    input  logic                     par_err,
    output logic                     TXD1,
    output logic                     TXD0,
    output logic                     SLP,
    output logic                     ce_tact,
    output logic [5:0]               cb_bit,
    output logic                     busy,
    output logic                     word_done,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam int HB_R0 = (CLK_HZ / 25000   < 1) ? 1 : CLK_HZ / 25000;
    localparam int HB_R1 = (CLK_HZ / 100000  < 1) ? 1 : CLK_HZ / 100000;
    localparam int HB_R2 = (CLK_HZ / 200000  < 1) ? 1 : CLK_HZ / 200000;
    localparam int HB_R3 = (CLK_HZ / 2000000 < 1) ? 1 : CLK_HZ / 2000000;
    localparam int CW    = $clog2(HB_R0 + 1);

    localparam int GW         = 5;
    localparam int GAP_HALVES = 2 * GAP_BITS;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   wr_frame;
    logic [31:0]   rd_frame;
    logic          push;
    logic          pop;

    state_t        state;
    logic [31:0]   sh;
    logic [CW-1:0] hb;
    logic [CW-1:0] hb_load;
    logic [CW-1:0] hcnt;
    logic          half;
    logic [4:0]    bitn;
    logic [GW-1:0] gcnt;
    logic          hb_end;
    logic          gap_end;

    // Frame is stored in line order: bit 31 goes out first, parity last.
    always_comb begin
        wr_frame[31:24] = ADR;
        for (int i = 0; i < 23; i++) begin
            wr_frame[23-i] = DAT[i];
        end
        wr_frame[0] = ^{ADR, DAT} ^ (PAR_ODD != 0) ^ par_err;
    end

    always_comb begin
        hb_load = CW'(HB_R0);
        case (Nvel)
            2'b00:   hb_load = CW'(HB_R0);
            2'b01:   hb_load = CW'(HB_R1);
            2'b10:   hb_load = CW'(HB_R2);
            default: hb_load = CW'(HB_R3);
        endcase
    end

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign rd_frame = mem[rd_ptr];
    assign hb_end   = (hcnt == hb - CW'(1));
    assign gap_end  = (state == GAP) && hb_end && (gcnt == GW'(GAP_HALVES - 1));
    assign pop      = !empty && ((state == IDLE) || gap_end);
    assign push     = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= wr_en && !push;
            if (push) begin
                mem[wr_ptr] <= wr_frame;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // A pop always wins: it covers both the idle start and the gap-end reload,
    // so consecutive words keep an exact period with no extra clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            hb        <= CW'(1);
            hcnt      <= '0;
            half      <= 1'b0;
            bitn      <= '0;
            gcnt      <= '0;
            TXD1      <= 1'b0;
            TXD0      <= 1'b0;
            SLP       <= 1'b0;
            ce_tact   <= 1'b0;
            cb_bit    <= '0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= gap_end;
            if (pop) begin
                state   <= SEND;
                sh      <= rd_frame;
                hb      <= hb_load;
                hcnt    <= '0;
                half    <= 1'b0;
                bitn    <= '0;
                TXD1    <= rd_frame[31];
                TXD0    <= !rd_frame[31];
                SLP     <= (Nvel == 2'b00);
                ce_tact <= (hb_load == CW'(1));
                cb_bit  <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        TXD1    <= 1'b0;
                        TXD0    <= 1'b0;
                        ce_tact <= 1'b0;
                        cb_bit  <= '0;
                        busy    <= 1'b0;
                    end
                    SEND: begin
                        if (!hb_end) begin
                            hcnt    <= hcnt + CW'(1);
                            ce_tact <= ((hcnt + CW'(1)) == (hb - CW'(1)));
                        end else begin
                            hcnt    <= '0;
                            ce_tact <= (hb == CW'(1));
                            if (!half) begin
                                half <= 1'b1;
                                TXD1 <= 1'b0;
                                TXD0 <= 1'b0;
                            end else begin
                                half <= 1'b0;
                                if (bitn == 5'd31) begin
                                    state  <= GAP;
                                    gcnt   <= '0;
                                    cb_bit <= '0;
                                end else begin
                                    bitn   <= bitn + 5'd1;
                                    cb_bit <= {1'b0, bitn + 5'd1};
                                    sh     <= {sh[30:0], 1'b0};
                                    TXD1   <= sh[30];
                                    TXD0   <= !sh[30];
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (!hb_end) begin
                            hcnt    <= hcnt + CW'(1);
                            ce_tact <= ((hcnt + CW'(1)) == (hb - CW'(1)));
                        end else if (gap_end) begin
                            state   <= IDLE;
                            hcnt    <= '0;
                            ce_tact <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            hcnt    <= '0;
                            gcnt    <= gcnt + GW'(1);
                            ce_tact <= (hb == CW'(1));
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ar_txd_fifo.sv
// tb/tb_ar_txd_fifo.sv - scoreboard bench for ar_txd_fifo
module tb_ar_txd_fifo;

    localparam int CLK_HZ   = 4000000;
    localparam int DEPTH    = 8;
    localparam int GAP_BITS = 4;
    localparam int PAR_ODD  = 1;
    localparam int WORD_HALVES = 2 * (32 + GAP_BITS);

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  Nvel;
    logic        wr_en;
    logic [7:0]  ADR;
    logic [22:0] DAT;
    logic        par_err;
    logic        TXD1, TXD0, SLP, ce_tact, busy, word_done, full, empty, ovf;
    logic [5:0]  cb_bit;
    logic [3:0]  level;

    ar_txd_fifo #(
        .CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .GAP_BITS(GAP_BITS), .PAR_ODD(PAR_ODD)
    ) dut (
        .clk(clk), .rst(rst), .Nvel(Nvel), .wr_en(wr_en), .ADR(ADR), .DAT(DAT),
        .par_err(par_err), .TXD1(TXD1), .TXD0(TXD0), .SLP(SLP), .ce_tact(ce_tact),
        .cb_bit(cb_bit), .busy(busy), .word_done(word_done), .full(full),
        .empty(empty), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  adr;
        logic [22:0] dat;
        logic        perr;
        longint      acc_edge;
    } exp_t;

    exp_t   expq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc = 0;
    logic [1:0] nvel_at = 2'b11;
    logic   rst_at = 1'b1;
    longint last_end = 0;
    longint cur_start = 0;
    int     n_started = 0;
    int     n_acc = 0;
    longint last_wr_edge = -1;
    bit     last_wr_acc = 1'b1;

    always @(posedge clk) begin
        cyc = cyc + 1;
        nvel_at = Nvel;
        rst_at = rst;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int hb_of(input logic [1:0] nv);
        int rate;
        case (nv)
            2'b00:   rate = 12500;
            2'b01:   rate = 50000;
            2'b10:   rate = 100000;
            default: rate = 1000000;
        endcase
        return CLK_HZ / (2 * rate);
    endfunction

    // Bit i of the result is the i-th bit placed on the line.
    function automatic logic [31:0] line_bits(input exp_t e);
        logic [31:0] b;
        int ones;
        for (int i = 0; i < 8; i++) b[i] = e.adr[7-i];
        for (int i = 0; i < 23; i++) b[8+i] = e.dat[i];
        ones = $countones({e.adr, e.dat});
        b[31] = ((PAR_ODD != 0) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ e.perr;
        return b;
    endfunction

    task automatic write_word(input logic [7:0] a, input logic [22:0] d, input logic p, input bit acc);
        ADR = a; DAT = d; par_err = p; wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        last_wr_edge = cyc;
        last_wr_acc  = acc;
        if (acc) begin
            expq.push_back('{adr: a, dat: d, perr: p, acc_edge: cyc});
            n_acc++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < budget, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_started(input int target);
        int n;
        n = 0;
        while (n_started < target && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("word_started", n_started >= target, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_at) begin
            if (cyc == last_wr_edge) chk("ovf", ovf, !last_wr_acc);
            else if (ovf !== 1'b0) chk("ovf_spurious", ovf, 0);
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [31:0] s;
        int          hb, hi, bi, errs, serrs;
        logic [1:0]  nv;
        longint      st, exp_s;
        bit          aborted, skip, x1, x0;
        int          xcb;
        skip = 1'b0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 1'b0;
            if (rst_at) begin
                last_end = cyc;
                continue;
            end
            if (!(TXD1 === 1'b1 || TXD0 === 1'b1)) continue;
            st = cyc;
            nv = nvel_at;
            hb = hb_of(nv);
            cur_start = st;
            n_started++;
            if (expq.size() == 0) begin
                chk("unexpected_word", 1, 0);
                for (int w = 0; w < 20000 && busy === 1'b1; w++) @(negedge clk);
                continue;
            end
            e = expq.pop_front();
            exp_s = (e.acc_edge + 1 > last_end) ? e.acc_edge + 1 : last_end;
            chk("start_edge", st, exp_s);
            s = line_bits(e);
            errs = 0; serrs = 0; aborted = 1'b0;
            for (int c = 0; c < WORD_HALVES * hb; c++) begin
                if (c > 0) @(negedge clk);
                if (rst_at) begin
                    aborted = 1'b1;
                    break;
                end
                hi = c / hb;
                if (hi < 64) begin
                    bi = hi / 2;
                    x1 = (hi % 2 == 0) && s[bi];
                    x0 = (hi % 2 == 0) && !s[bi];
                    xcb = bi;
                end else begin
                    x1 = 1'b0; x0 = 1'b0; xcb = 0;
                end
                if (TXD1 !== x1 || TXD0 !== x0) errs++;
                if (ce_tact !== ((c % hb) == hb - 1) || cb_bit !== 6'(xcb) ||
                    busy !== 1'b1 || SLP !== (nv == 2'b00)) serrs++;
            end
            if (aborted) begin
                last_end = cyc;
                continue;
            end
            chk("word_lines", errs, 0);
            chk("word_strobes", serrs, 0);
            last_end = st + WORD_HALVES * hb;
            @(negedge clk);
            if (!rst_at) begin
                chk("word_done", word_done, 1);
                chk("busy_after_word", busy, (expq.size() > 0) && (expq[0].acc_edge < last_end));
            end
            skip = 1'b1;
        end
    end

    initial begin : watchdog
        #(10 * 95000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        longint pop_edge, tgt;
        int base, t;
        rst = 1'b1; Nvel = 2'b11; wr_en = 1'b0; ADR = '0; DAT = '0; par_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txd1", TXD1, 0);
        chk("rst_txd0", TXD0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_outs", {SLP, ce_tact, cb_bit, word_done, ovf}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        Nvel = 2'b11;
        write_word(8'hA5, 23'h000001, 1'b0, 1'b1);
        @(negedge clk);
        chk("level_one", level, 1);
        chk("no_pulse_yet", TXD1, 0);
        @(negedge clk);
        chk("first_pulse", TXD1, 1);
        chk("busy_on", busy, 1);
        @(posedge clk);
        #1;
        drain(2000);
        write_word(8'hA5, 23'h000001, 1'b1, 1'b1);
        drain(2000);

        Nvel = 2'b10;
        for (int i = 0; i < 9; i++) write_word(8'(i * 17 + 3), 23'($urandom), 1'($urandom), 1'b1);
        @(negedge clk);
        chk("full_set", full, 1);
        chk("level_full", level, DEPTH);
        @(posedge clk);
        #1;
        write_word(8'hEE, 23'h7FFFFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("level_after_drop", level, DEPTH);
        @(posedge clk);
        #1;
        pop_edge = cur_start + WORD_HALVES * hb_of(2'b10);
        t = 0;
        while (cyc != pop_edge - 1 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("reach_pop_edge", cyc, pop_edge - 1);
        write_word(8'h3C, 23'h155555, 1'b0, 1'b1);
        @(negedge clk);
        chk("level_push_pop", level, DEPTH);
        chk("full_push_pop", full, 1);
        @(posedge clk);
        #1;
        drain(20000);

        Nvel = 2'b00;
        base = n_started;
        write_word(8'h81, 23'h0F0F0F, 1'b0, 1'b1);
        write_word(8'h42, 23'h123456, 1'b0, 1'b1);
        wait_started(base + 1);
        repeat (500) @(posedge clk);
        #1;
        chk("slp_slow", SLP, 1);
        Nvel = 2'b11;
        drain(15000);
        chk("slp_fast", SLP, 0);

        Nvel = 2'b11;
        base = n_started;
        for (int i = 0; i < 4; i++) write_word(8'(8'hC0 + i), 23'($urandom), 1'b0, 1'b1);
        wait_started(base + 1);
        tgt = cur_start + 10 * 2 * hb_of(2'b11);
        t = 0;
        while (cyc < tgt && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        n_acc = 0;
        n_started = 0;
        @(negedge clk);
        chk("rst_mid_txd", {TXD1, TXD0}, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_busy", busy, 0);
        @(posedge clk);
        #1;
        write_word(8'h5A, 23'h2AAAAA, 1'b0, 1'b1);
        drain(2000);

        for (int k = 0; k < 16; k++) begin
            Nvel = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
            repeat ($urandom_range(0, 150)) @(posedge clk);
            #1;
            t = 0;
            while (n_acc - n_started >= DEPTH - 1 && t < 5000) begin
                @(posedge clk);
                #1;
                t++;
            end
            write_word(8'($urandom), 23'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1);
        end
        drain(30000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
